// File: rtl/fir_controller_p_if.sv
// fir_controller_p_if: handshake and register-file command bus between FIR controller and datapath
interface fir_controller_p_if #(parameter int REG_AW = 4);
  logic dr;
  logic lc;
  logic overflow;
  logic cnt_up;
  logic clear;
  logic modwait;
  logic err;
  logic [2:0] op;
  logic [REG_AW-1:0] src1;
  logic [REG_AW-1:0] src2;
  logic [REG_AW-1:0] dest;
  modport master (output dr, lc, overflow, input cnt_up, clear, modwait, err, op, src1, src2, dest);
  modport slave (input dr, lc, overflow, output cnt_up, clear, modwait, err, op, src1, src2, dest);
endinterface

// File: rtl/fir_controller_p.sv
// fir_controller_p: sequences coefficient loads and per-sample FIR multiply/accumulate ops on a register-file datapath
module fir_controller_p #(
  parameter int NTAPS = 4,
  parameter int REG_AW = 4,
  parameter int ALT_SIGN = 1
) (
  input logic clk,
  input logic n_rst,
  fir_controller_p_if.slave bus
);
  localparam int KW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int T = 2 * NTAPS + 2;
  localparam logic [KW-1:0] KLAST = KW'(NTAPS - 1);
  if (NTAPS < 2 || NTAPS > 8) begin : g_bad_ntaps
    $error("fir_controller_p: NTAPS must be 2..8");
  end
  if (2 * NTAPS + 2 > 2 ** REG_AW - 1) begin : g_bad_aw
    $error("fir_controller_p: REG_AW too narrow for register map");
  end
  typedef enum logic [3:0] {IDLE, LOAD, LWAIT, STORE, ZERO, SORT, MUL, ACC, EIDLE} state_t;
  state_t state, state_n;
  logic [KW-1:0] k, k_n;
  // state and tap counter; reset abandons any partial load or filter pass
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state <= IDLE;
      k <= '0;
    end else begin
      state <= state_n;
      k <= k_n;
    end
  end
  // next state and Moore output decode from {state,k}
  always_comb begin
    state_n = state;
    k_n = k;
    bus.cnt_up = 1'b0;
    bus.clear = 1'b0;
    bus.modwait = 1'b1;
    bus.err = 1'b0;
    bus.op = 3'b000;
    bus.src1 = '0;
    bus.src2 = '0;
    bus.dest = '0;
    case (state)
      IDLE: begin
        bus.modwait = 1'b0;
        if (bus.dr) state_n = STORE;
        else if (bus.lc) begin
          state_n = LOAD;
          k_n = '0;
        end
      end
      LOAD: begin
        bus.op = 3'b011;
        bus.dest = REG_AW'(2 * NTAPS + 1 - int'(k));
        bus.clear = 1'b1;
        state_n = (k == KLAST) ? IDLE : LWAIT;
        k_n = (k == KLAST) ? '0 : k + 1'b1;
      end
      LWAIT: begin
        bus.clear = 1'b1;
        bus.modwait = 1'b0;
        if (bus.lc) state_n = LOAD;
      end
      STORE: begin
        bus.op = 3'b010;
        bus.dest = REG_AW'(NTAPS + 1);
        state_n = bus.dr ? ZERO : EIDLE;
      end
      ZERO: begin
        bus.op = 3'b101;
        bus.src1 = REG_AW'(NTAPS + 1);
        bus.src2 = REG_AW'(NTAPS + 1);
        bus.cnt_up = 1'b1;
        state_n = SORT;
        k_n = '0;
      end
      SORT: begin
        bus.op = 3'b001;
        bus.src1 = REG_AW'(int'(k) + 2);
        bus.dest = REG_AW'(int'(k) + 1);
        state_n = (k == KLAST) ? MUL : SORT;
        k_n = (k == KLAST) ? '0 : k + 1'b1;
      end
      MUL: begin
        bus.op = 3'b110;
        bus.src1 = REG_AW'(int'(k) + 1);
        bus.src2 = REG_AW'(NTAPS + 2 + int'(k));
        bus.dest = REG_AW'(T);
        state_n = ACC;
      end
      ACC: begin
        bus.op = (ALT_SIGN == 0 || !k[0]) ? 3'b100 : 3'b101;
        bus.src2 = REG_AW'(T);
        state_n = bus.overflow ? EIDLE : (k == KLAST) ? IDLE : MUL;
        k_n = (bus.overflow || k == KLAST) ? '0 : k + 1'b1;
      end
      EIDLE: begin
        bus.err = 1'b1;
        bus.modwait = 1'b0;
        if (bus.dr) state_n = STORE;
      end
      default: begin
        state_n = IDLE;
        k_n = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_fir_controller_p.sv
// tb_fir_controller_p: directed checks of load, filter, error and reset sequencing for two configurations
module tb_fir_controller_p;
  logic clk;
  logic rst_a;
  logic rst_b;
  int n_cmp = 0;
  int n_bad = 0;
  int busy;
  fir_controller_p_if #(.REG_AW(4)) ba();
  fir_controller_p_if #(.REG_AW(4)) bb();
  fir_controller_p #(.NTAPS(4), .REG_AW(4), .ALT_SIGN(1)) dut_a (.clk(clk), .n_rst(rst_a), .bus(ba));
  fir_controller_p #(.NTAPS(6), .REG_AW(4), .ALT_SIGN(0)) dut_b (.clk(clk), .n_rst(rst_b), .bus(bb));
  logic [18:0] oa, ob;
  assign oa = {ba.err, ba.modwait, ba.clear, ba.cnt_up, ba.op, ba.src1, ba.src2, ba.dest};
  assign ob = {bb.err, bb.modwait, bb.clear, bb.cnt_up, bb.op, bb.src1, bb.src2, bb.dest};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [18:0] v(input logic er, mw, cl, cu, input logic [2:0] o, input int s1, s2, d);
    return {er, mw, cl, cu, o, 4'(s1), 4'(s2), 4'(d)};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_a = 1; rst_b = 1;
    ba.dr = 0; ba.lc = 0; ba.overflow = 0;
    bb.dr = 0; bb.lc = 0; bb.overflow = 0;
    #2;
    check("rst_a", oa, 0);
    check("rst_b", ob, 0);
    tick();
    rst_a = 0; rst_b = 0;
    tick();
    check("idle_a", oa, 0);
    for (int i = 0; i < 4; i++) begin
      ba.lc = 1;
      tick();
      ba.lc = 0;
      check($sformatf("load%0d", i), oa, v(0, 1, 1, 0, 3'b011, 0, 0, 9 - i));
      tick();
      check($sformatf("after_load%0d", i), oa, (i < 3) ? v(0, 0, 1, 0, 0, 0, 0, 0) : 19'd0);
      if (i == 1) begin
        ba.dr = 1;
        tick();
        ba.dr = 0;
        check("lwait_dr", oa, v(0, 0, 1, 0, 0, 0, 0, 0));
      end
    end
    ba.dr = 1;
    busy = 0;
    tick(); busy += int'(ba.modwait);
    check("store", oa, v(0, 1, 0, 0, 3'b010, 0, 0, 5));
    tick(); busy += int'(ba.modwait);
    check("zero", oa, v(0, 1, 0, 1, 3'b101, 5, 5, 0));
    for (int k = 0; k < 4; k++) begin
      tick(); busy += int'(ba.modwait);
      check($sformatf("sort%0d", k), oa, v(0, 1, 0, 0, 3'b001, k + 2, 0, k + 1));
    end
    for (int k = 0; k < 4; k++) begin
      tick(); busy += int'(ba.modwait);
      check($sformatf("mul%0d", k), oa, v(0, 1, 0, 0, 3'b110, k + 1, 6 + k, 10));
      tick(); busy += int'(ba.modwait);
      check($sformatf("acc%0d", k), oa, v(0, 1, 0, 0, (k % 2) ? 3'b101 : 3'b100, 0, 10, 0));
    end
    ba.dr = 0;
    tick(); busy += int'(ba.modwait);
    check("idle_after", oa, 0);
    check("busy_a", busy, 14);
    ba.dr = 1;
    tick();
    tick();
    ba.overflow = 1;
    for (int k = 0; k < 4; k++) tick();
    check("sort3_ovf", oa, v(0, 1, 0, 0, 3'b001, 5, 0, 4));
    tick();
    check("mul0_ovf", oa, v(0, 1, 0, 0, 3'b110, 1, 6, 10));
    ba.overflow = 0;
    tick();
    check("acc0_ok", oa, v(0, 1, 0, 0, 3'b100, 0, 10, 0));
    tick();
    check("mul1", oa, v(0, 1, 0, 0, 3'b110, 2, 7, 10));
    tick();
    check("acc1", oa, v(0, 1, 0, 0, 3'b101, 0, 10, 0));
    ba.overflow = 1;
    ba.dr = 0;
    tick();
    ba.overflow = 0;
    check("eidle_ovf", oa, v(1, 0, 0, 0, 0, 0, 0, 0));
    ba.lc = 1;
    tick();
    ba.lc = 0;
    check("eidle_lc", oa, v(1, 0, 0, 0, 0, 0, 0, 0));
    ba.dr = 1;
    tick();
    check("eidle_store", oa, v(0, 1, 0, 0, 3'b010, 0, 0, 5));
    ba.dr = 0;
    tick();
    check("store_drop", oa, v(1, 0, 0, 0, 0, 0, 0, 0));
    #2 rst_a = 1;
    #1 check("rst_eidle", oa, 0);
    @(negedge clk) rst_a = 0;
    ba.dr = 1; ba.lc = 1;
    tick();
    ba.lc = 0;
    check("dr_lc_prio", oa, v(0, 1, 0, 0, 3'b010, 0, 0, 5));
    tick();
    tick();
    tick();
    check("sort1", oa, v(0, 1, 0, 0, 3'b001, 3, 0, 2));
    #2 rst_a = 1;
    #1 check("rst_sort", oa, 0);
    ba.dr = 0;
    @(negedge clk) rst_a = 0;
    tick();
    check("idle_post_sort", oa, 0);
    for (int i = 0; i < 2; i++) begin
      ba.lc = 1;
      tick();
      ba.lc = 0;
      tick();
    end
    check("lwait2", oa, v(0, 0, 1, 0, 0, 0, 0, 0));
    #2 rst_a = 1;
    #1 check("rst_lwait", oa, 0);
    @(negedge clk) rst_a = 0;
    ba.lc = 1;
    tick();
    ba.lc = 0;
    check("reload0", oa, v(0, 1, 1, 0, 3'b011, 0, 0, 9));
    bb.dr = 1;
    busy = 0;
    tick(); busy += int'(bb.modwait);
    check("b_store", ob, v(0, 1, 0, 0, 3'b010, 0, 0, 7));
    tick(); busy += int'(bb.modwait);
    check("b_zero", ob, v(0, 1, 0, 1, 3'b101, 7, 7, 0));
    for (int k = 0; k < 6; k++) begin
      tick(); busy += int'(bb.modwait);
      check($sformatf("b_sort%0d", k), ob, v(0, 1, 0, 0, 3'b001, k + 2, 0, k + 1));
    end
    for (int k = 0; k < 6; k++) begin
      tick(); busy += int'(bb.modwait);
      check($sformatf("b_mul%0d", k), ob, v(0, 1, 0, 0, 3'b110, k + 1, 8 + k, 14));
      tick(); busy += int'(bb.modwait);
      check($sformatf("b_acc%0d", k), ob, v(0, 1, 0, 0, 3'b100, 0, 14, 0));
    end
    bb.dr = 0;
    tick(); busy += int'(bb.modwait);
    check("b_idle", ob, 0);
    check("busy_b", busy, 20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fir_controller_p.md
FIR_CONTROLLER_P -- requirements
Module: fir_controller_p

Interface
REQ-001 SHALL have parameter NTAPS, default 4, meaning filter tap count; legal range 2..8.
REQ-002 SHALL have parameter REG_AW, default 4, meaning register-file address width; elaboration SHALL fail if 2*NTAPS+2 > 2**REG_AW-1.
REQ-003 SHALL have parameter ALT_SIGN, default 1, meaning 1 = alternating +,-,+,- tap accumulation and 0 = all taps added.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit, meaning rising-edge clock.
REQ-006 SHALL have port n_rst, input, 1 bit, meaning asynchronous reset, asserted when 1.
REQ-007 SHALL have port dr, input, 1 bit, meaning new sample ready.
REQ-008 SHALL have port lc, input, 1 bit, meaning load coefficient.
REQ-009 SHALL have port overflow, input, 1 bit, meaning datapath ALU overflow on the current op.
REQ-010 SHALL have port cnt_up, output, 1 bit, meaning sample-counter increment.
REQ-011 SHALL have port clear, output, 1 bit, meaning sample-counter clear.
REQ-012 SHALL have port modwait, output, 1 bit, meaning controller busy.
REQ-013 SHALL have port op, output, 3 bits, meaning datapath op: 000 NOP, 001 COPY, 010 LOAD_SAMPLE, 011 LOAD_COEF, 100 ADD, 101 SUB, 110 MUL.
REQ-014 SHALL have ports src1, src2 and dest, output, REG_AW bits each, meaning register-file addresses.
REQ-015 SHALL have port err, output, 1 bit, meaning error-idle indication.

Function
REQ-016 Register map SHALL be: reg 0 accumulator; regs 1..NTAPS sample history (1 oldest); reg NTAPS+1 new sample; regs NTAPS+2..2*NTAPS+1 coefficients; reg T=2*NTAPS+2 product temp.
REQ-017 SHALL implement states IDLE, LOAD, LWAIT, STORE, ZERO, SORT, MUL, ACC and EIDLE, plus a tap/coefficient counter k of width clog2(NTAPS).
REQ-018 Outputs SHALL be Moore-decoded from {state,k}; defaults SHALL be all zero except modwait=1.
REQ-019 In IDLE, modwait SHALL be 0 and all other outputs 0; dr=1 SHALL go to STORE; else lc=1 SHALL go to LOAD with k=0; dr SHALL take precedence when both are high.
REQ-020 In LOAD: op=011, dest=2*NTAPS+1-k, clear=1, modwait=1; SHALL go to IDLE if k=NTAPS-1, else to LWAIT with k+1.
REQ-021 In LWAIT: clear=1, modwait=0; lc=1 SHALL go to LOAD; dr SHALL be ignored.
REQ-022 In STORE: op=010, dest=NTAPS+1; dr=0 SHALL go to EIDLE; dr=1 SHALL go to ZERO.
REQ-023 In ZERO: op=101, src1=src2=NTAPS+1, dest=0, cnt_up=1; SHALL go to SORT with k=0.
REQ-024 In SORT(k): op=001, src1=k+2, dest=k+1; after k=NTAPS-1 SHALL go to MUL with k=0.
REQ-025 In MUL(k): op=110, src1=k+1, src2=NTAPS+2+k, dest=T; SHALL go to ACC.
REQ-026 In ACC(k): op=100 if ALT_SIGN=0 or k even, else op=101; src1=0, src2=T, dest=0.
REQ-027 From ACC, overflow=1 SHALL go to EIDLE; else k=NTAPS-1 SHALL go to IDLE; else SHALL go to MUL with k+1.
REQ-028 overflow SHALL be ignored in all states other than ACC.
REQ-029 lc SHALL be ignored in every state except IDLE and LWAIT.
REQ-030 In EIDLE: err=1, modwait=0; dr=1 SHALL go to STORE; lc SHALL be ignored; err SHALL drop in the cycle STORE is entered.
REQ-031 A sample SHALL take 3*NTAPS+2 busy cycles, from STORE through the last ACC (14 for NTAPS=4); modwait SHALL fall the cycle after the last ACC.

Reset
REQ-032 n_rst=1 SHALL force state IDLE and k=0 immediately, independent of clk, including mid-load and mid-filter.
REQ-033 During reset, outputs SHALL be cnt_up=0, clear=0, modwait=0, op=000, src1=src2=dest=0, err=0.
REQ-034 After reset, no partially loaded coefficient state SHALL be retained; the next lc SHALL restart at k=0.

Verification
REQ-035 NTAPS=4, ALT_SIGN=1: four lc pulses -> LOAD dests 9,8,7,6 with clear=1; modwait=1 only in LOAD cycles.
REQ-036 NTAPS=4, dr held high -> 14 busy cycles; ops 010,101,001x4, then 110/100, 110/101, 110/100, 110/101; MUL src pairs (1,6),(2,7),(3,8),(4,9); cnt_up=1 only in ZERO.
REQ-037 NTAPS=6, ALT_SIGN=0 -> 20 busy cycles, all ACC ops 100, coefficient regs 8..13, T=14.
REQ-038 overflow=1 during the second ACC -> EIDLE next cycle, err=1; next dr -> err=0, STORE.
REQ-039 dr dropped during STORE -> EIDLE, err=1; dr and lc high together in IDLE -> STORE.
REQ-040 n_rst pulsed during SORT, then during LWAIT after 2 loads -> async return to IDLE with outputs zero; next lc -> dest 2*NTAPS+1.
